cdc_fifo_write_state: RTL

Write-domain pointer and status logic for the dual-clock CDC FIFO. It tracks the binary write address and publishes a registered Gray-coded copy for the read domain. It synchronises the read domain's Gray read pointer into the write clock and derives full, almost-full, fill level and memory write strobe. It is the write-side counterpart of the read-state block and drives the write port of the FIFO storage array.

---
 rtl/cdc_fifo_pkg.sv | 43 ++++
 rtl/cdc_fifo_pointer_sync.sv | 44 ++++
 rtl/cdc_fifo_write_state.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// cdc_fifo_pkg
//
// Shared constants and pointer-code helpers for the dual-clock CDC FIFO.
// Both the write-state and read-state blocks import this package so that the
// Gray encoding used on each side of the clock boundary is the same.
//
// Contents:
//   DEFAULT_ADDRESS_WIDTH : default pointer width (FIFO depth 2**width)
//   DEFAULT_SYNC_STAGES   : default number of flops in a pointer synchroniser
//   CONVERT_WIDTH         : working width of the conversion functions; callers
//                           zero-extend into it and size-cast the result back
//   binary_to_gray()      : binary -> reflected Gray code
//   gray_to_binary()      : reflected Gray code -> binary
// -----------------------------------------------------------------------------
package cdc_fifo_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 4;
  localparam int DEFAULT_SYNC_STAGES   = 2;

  // Pointers wider than this are not supported by the helpers below.
  localparam int CONVERT_WIDTH = 32;

  function automatic logic [CONVERT_WIDTH-1:0] binary_to_gray(
    input logic [CONVERT_WIDTH-1:0] binary
  );
    return binary ^ (binary >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; zero-extended
  // upper bits leave the low-order result untouched.
  function automatic logic [CONVERT_WIDTH-1:0] gray_to_binary(
    input logic [CONVERT_WIDTH-1:0] gray
  );
    logic [CONVERT_WIDTH-1:0] binary;
    binary[CONVERT_WIDTH-1] = gray[CONVERT_WIDTH-1];
    for (int i = CONVERT_WIDTH - 2; i >= 0; i--) begin
      binary[i] = binary[i+1] ^ gray[i];
    end
    return binary;
  endfunction

endpackage

// File: rtl/cdc_fifo_pointer_sync.sv
// -----------------------------------------------------------------------------
// cdc_fifo_pointer_sync
//
// Multi-flop bus synchroniser for a Gray-coded FIFO pointer. The bus may only
// be a Gray value (at most one bit changing per source update), so each bit
// can be resynchronised independently without producing an invalid pointer.
// Shared by the write-state and read-state blocks.
//
// Parameters:
//   WIDTH  : bus width
//   STAGES : number of flops in the chain (must be 2 or more)
//
// Ports:
//   clock  in   destination-domain clock
//   reset  in   synchronous active-high reset, clears every stage to 0
//   i_data in   Gray pointer from the other clock domain (asynchronous)
//   o_data out  synchronised pointer, STAGES edges behind i_data
// -----------------------------------------------------------------------------
module cdc_fifo_pointer_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  // All stages held in one flat shift chain; the newest sample sits in the
  // low WIDTH bits and the oldest (fully resolved) sample in the top WIDTH.
  (* ASYNC_REG = "TRUE" *)
  logic [STAGES*WIDTH-1:0] r_chain;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[(STAGES-1)*WIDTH-1:0], i_data};
    end
  end

  assign o_data = r_chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/cdc_fifo_write_state.sv
// -----------------------------------------------------------------------------
// cdc_fifo_write_state
//
// Write-domain pointer and status logic of the dual-clock CDC FIFO. Keeps the
// binary write address for the storage array, publishes a registered Gray copy
// for the read domain, brings the read domain's Gray pointer across with a
// multi-flop synchroniser and derives full / almost_full / level / write
// strobe from the two pointers. Status is pessimistic: a read is seen
// SYNC_STAGES edges late, so full can linger but never drops early.
//
// One slot is always left empty so that equal pointers mean "empty" and
// write+1 == read means "full"; usable capacity is 2**ADDRESS_WIDTH - 1.
//
// Build option:
//   CDC_FIFO_WRITE_OVERFLOW_EN defined   : sticky overflow flag, set by a write
//                                          request while full, cleared by reset.
//   CDC_FIFO_WRITE_OVERFLOW_EN undefined : overflow tied to 0, dropped writes
//                                          are silent.
//
// Parameters:
//   ADDRESS_WIDTH     : pointer width (up to 32)
//   SYNC_STAGES       : read-pointer synchroniser depth (2 or more)
//   ALMOST_FULL_LEVEL : level at or above which almost_full asserts
//
// Ports:
//   clock              in   write-domain clock
//   reset              in   synchronous active-high reset
//   increment          in   write request this cycle
//   read_address_gray  in   Gray read pointer from the read domain (async)
//   write_address      out  binary write address to the storage array
//   write_address_gray out  registered Gray write pointer to the read domain
//   write_enable       out  storage write strobe (increment & !full)
//   full               out  no free slot
//   almost_full        out  level >= ALMOST_FULL_LEVEL
//   level              out  occupied slots as seen in the write domain
//   overflow           out  sticky "write attempted while full"
// -----------------------------------------------------------------------------
module cdc_fifo_write_state
  import cdc_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = DEFAULT_ADDRESS_WIDTH,
  parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
  parameter int ALMOST_FULL_LEVEL = (1 << ADDRESS_WIDTH) - 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     increment,
  input  logic [ADDRESS_WIDTH-1:0] read_address_gray,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [ADDRESS_WIDTH-1:0] write_address_gray,
  output logic                     write_enable,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDRESS_WIDTH-1:0] level,
  output logic                     overflow
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] r_write_address;
  logic [ADDRESS_WIDTH-1:0] r_write_address_gray;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] w_read_gray_sync;
  logic [ADDRESS_WIDTH-1:0] w_read_address_sync;
  logic [ADDRESS_WIDTH-1:0] w_write_address_next;
  logic [ADDRESS_WIDTH-1:0] w_write_gray_next;
  logic [ADDRESS_WIDTH-1:0] w_level;
  logic                     w_full;
  logic                     w_write_accept;

  // ---------------------------------------------------------------------------
  // Read pointer into the write clock domain. Only the Gray value crosses;
  // decoding to binary happens after the last synchroniser flop.
  // ---------------------------------------------------------------------------
  cdc_fifo_pointer_sync #(
    .WIDTH  (ADDRESS_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_read_pointer_sync (
    .clock  (clock),
    .reset  (reset),
    .i_data (read_address_gray),
    .o_data (w_read_gray_sync)
  );

  assign w_read_address_sync =
    ADDRESS_WIDTH'(gray_to_binary(CONVERT_WIDTH'(w_read_gray_sync)));

  // ---------------------------------------------------------------------------
  // Pointer arithmetic and status. The +1 and the subtraction wrap naturally
  // at ADDRESS_WIDTH bits, so pointer wrap needs no special case.
  // ---------------------------------------------------------------------------
  assign w_write_address_next = r_write_address + 1'b1;
  assign w_write_gray_next    =
    ADDRESS_WIDTH'(binary_to_gray(CONVERT_WIDTH'(w_write_address_next)));

  assign w_full         = (w_write_address_next == w_read_address_sync);
  assign w_write_accept = increment & ~w_full;
  assign w_level        = r_write_address - w_read_address_sync;

  // Registered Gray copy is loaded with the same edge as the binary address,
  // so the read domain only ever sees a glitch-free, single-bit step.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_address      <= '0;
      r_write_address_gray <= '0;
    end else if (w_write_accept) begin
      r_write_address      <= w_write_address_next;
      r_write_address_gray <= w_write_gray_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional sticky overflow flag
  // ---------------------------------------------------------------------------
`ifdef CDC_FIFO_WRITE_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (increment & w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign write_address      = r_write_address;
  assign write_address_gray = r_write_address_gray;
  assign write_enable       = w_write_accept;
  assign full               = w_full;
  assign level              = w_level;
  assign almost_full        = (int'(w_level) >= ALMOST_FULL_LEVEL);

endmodule
